// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul tile loader.
//   DWIDTH   element width in bits
//   MAT_SIZE tile dimension; one RAM word holds MAT_SIZE elements
//   AWIDTH   RAM word-address width
//   loader_state_e  loader FSM state encoding
package matmul_pkg;

    localparam int DWIDTH   = 8;
    localparam int MAT_SIZE = 4;
    localparam int AWIDTH   = 10;
    localparam int WWIDTH   = DWIDTH * MAT_SIZE;
    localparam int NELEM    = MAT_SIZE * MAT_SIZE;
    localparam int CWIDTH   = $clog2(NELEM);
    localparam int RWIDTH   = $clog2(MAT_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        WRITE_A,
        LOAD_B,
        RUN,
        WAIT_CLR
    } loader_state_e;

endpackage

// File: rtl/mat_transpose_buf.sv
// 4x4 element staging buffer. Written row-major one element at a time,
// read one column at a time as a packed word (row 0 element in the LSB).
// Ports:
//   clk, resetn      clock, async active-low reset (clears contents)
//   wr_en            write strobe
//   wr_idx           row-major element index {row, col}
//   wr_data          element value
//   rd_col           column to read
//   rd_data          packed column {e[3][col], e[2][col], e[1][col], e[0][col]}
module mat_transpose_buf
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [CWIDTH-1:0] wr_idx,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [RWIDTH-1:0] rd_col,
    output logic [WWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [NELEM];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NELEM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < MAT_SIZE; r++) begin
            rd_data[r*DWIDTH +: DWIDTH] = mem[{RWIDTH'(r), rd_col}];
        end
    end

endmodule

// File: rtl/mat_tile_loader.sv
// Feeds one 4x4 A/B operand tile pair from a byte stream into the matmul RAMs,
// then starts the matmul and waits for it to finish.
//   A (row-major in) is written transposed: word k = column k, A[0][k] in LSB.
//   B (row-major in) is written as-is:      word i = row i,    B[i][0] in LSB.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   in_valid/in_ready/in_data      element byte stream
//   in_first                       marks A[0][0] of a tile pair
//   cfg_is_fp8, base_addr_a/b      format and RAM bases, latched with in_first
//   a_we/a_addr/a_wdata            A RAM write port
//   b_we/b_addr/b_wdata            B RAM write port
//   mm_is_fp8, mm_start, mm_done   matmul control
//   busy, tile_done, proto_err     status; tile_done/proto_err are 1-cycle pulses
// Build option:
//   MAT_LOADER_PERF_EN adds perf_cycles[15:0], a saturating count of RUN cycles
//   cleared on entry to RUN.
//
// state    | meaning
// IDLE     | waiting for an in_first byte
// LOAD_A   | collecting the 16 A bytes into the staging buffer
// WRITE_A  | writing the 4 transposed A columns
// LOAD_B   | collecting B bytes, writing each row the cycle after it completes
// RUN      | mm_start held high until mm_done
// WAIT_CLR | waiting for mm_done to drop so it cannot end the next tile
module mat_tile_loader
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_first,
    input  logic              cfg_is_fp8,
    input  logic [AWIDTH-1:0] base_addr_a,
    input  logic [AWIDTH-1:0] base_addr_b,
    output logic              a_we,
    output logic [AWIDTH-1:0] a_addr,
    output logic [WWIDTH-1:0] a_wdata,
    output logic              b_we,
    output logic [AWIDTH-1:0] b_addr,
    output logic [WWIDTH-1:0] b_wdata,
    output logic              mm_is_fp8,
    output logic              mm_start,
    input  logic              mm_done,
    output logic              busy,
    output logic              tile_done,
    output logic              proto_err
`ifdef MAT_LOADER_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    loader_state_e state_q, state_d;

    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic              b_full_q, b_full_d;
    logic              fmt_q;
    logic [AWIDTH-1:0] base_a_q, base_b_q;
    logic [(MAT_SIZE-1)*DWIDTH-1:0] row_sr_q;
    logic              b_we_q;
    logic [AWIDTH-1:0] b_addr_q;
    logic [WWIDTH-1:0] b_wdata_q;
    logic              tile_done_q, proto_err_q;

    logic              accept, capture, err, buf_we, b_shift, row_done, done_hit;
    logic [CWIDTH-1:0] buf_idx;
    logic [WWIDTH-1:0] col_data;

    mat_transpose_buf u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (buf_we),
        .wr_idx  (buf_idx),
        .wr_data (in_data),
        .rd_col  (cnt_q[RWIDTH-1:0]),
        .rd_data (col_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_full_d = b_full_q;
        capture  = 1'b0;
        err      = 1'b0;
        buf_we   = 1'b0;
        buf_idx  = cnt_q;
        b_shift  = 1'b0;
        row_done = 1'b0;
        done_hit = 1'b0;
        // Once all 16 B bytes are in, stop accepting while the last row is written.
        in_ready = resetn && ((state_q == IDLE) || (state_q == LOAD_A) ||
                              ((state_q == LOAD_B) && !b_full_q));
        accept   = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_first) capture = 1'b1;
                    else          err     = 1'b1;
                end
            end
            LOAD_A: begin
                if (accept) begin
                    if (in_first) begin
                        capture = 1'b1;
                        err     = 1'b1;
                    end else begin
                        buf_we = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CWIDTH'(NELEM-1)) state_d = WRITE_A;
                    end
                end
            end
            WRITE_A: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q[RWIDTH-1:0] == RWIDTH'(MAT_SIZE-1)) begin
                    state_d  = LOAD_B;
                    cnt_d    = '0;
                    b_full_d = 1'b0;
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (in_first) begin
                        capture = 1'b1;
                        err     = 1'b1;
                    end else begin
                        b_shift = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q[RWIDTH-1:0] == RWIDTH'(MAT_SIZE-1)) row_done = 1'b1;
                        if (cnt_q == CWIDTH'(NELEM-1)) b_full_d = 1'b1;
                    end
                end
                // b_we_q with b_full_q set is the row-3 write in progress.
                if (b_full_q && b_we_q) state_d = RUN;
            end
            RUN: begin
                if (mm_done) begin
                    state_d  = WAIT_CLR;
                    done_hit = 1'b1;
                end
            end
            WAIT_CLR: begin
                if (!mm_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // in_first always starts a fresh tile with this byte as A[0][0].
        if (capture) begin
            state_d  = LOAD_A;
            cnt_d    = CWIDTH'(1);
            b_full_d = 1'b0;
            buf_we   = 1'b1;
            buf_idx  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            b_full_q    <= 1'b0;
            fmt_q       <= 1'b0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            row_sr_q    <= '0;
            b_we_q      <= 1'b0;
            b_addr_q    <= '0;
            b_wdata_q   <= '0;
            tile_done_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            b_full_q    <= b_full_d;
            tile_done_q <= done_hit;
            proto_err_q <= err;
            b_we_q      <= row_done;
            if (capture) begin
                fmt_q    <= cfg_is_fp8;
                base_a_q <= base_addr_a;
                base_b_q <= base_addr_b;
            end
            // Shift right so the oldest byte of the row ends up in the LSB.
            if (b_shift) begin
                row_sr_q <= {in_data, row_sr_q[(MAT_SIZE-1)*DWIDTH-1:DWIDTH]};
            end
            if (row_done) begin
                b_addr_q  <= base_b_q + AWIDTH'(cnt_q[CWIDTH-1:RWIDTH]);
                b_wdata_q <= {in_data, row_sr_q};
            end
        end
    end

    always_comb begin
        a_we      = (state_q == WRITE_A);
        a_addr    = a_we ? (base_a_q + AWIDTH'(cnt_q[RWIDTH-1:0])) : '0;
        a_wdata   = a_we ? col_data : '0;
        b_we      = b_we_q;
        b_addr    = b_addr_q;
        b_wdata   = b_wdata_q;
        mm_is_fp8 = fmt_q;
        mm_start  = (state_q == RUN);
        busy      = (state_q != IDLE);
        tile_done = tile_done_q;
        proto_err = proto_err_q;
    end

`ifdef MAT_LOADER_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if ((state_d == RUN) && (state_q != RUN)) begin
            perf_q <= '0;
        end else if ((state_q == RUN) && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mat_tile_loader.sv
module tb_mat_tile_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_first = 1'b0;
    logic        cfg_is_fp8 = 1'b0;
    logic [9:0]  base_addr_a = '0;
    logic [9:0]  base_addr_b = '0;
    logic        a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        mm_is_fp8, mm_start, busy, tile_done, proto_err;
    logic        mm_done = 1'b0;

    mat_tile_loader dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_first    (in_first),
        .cfg_is_fp8  (cfg_is_fp8),
        .base_addr_a (base_addr_a),
        .base_addr_b (base_addr_b),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .mm_is_fp8   (mm_is_fp8),
        .mm_start    (mm_start),
        .mm_done     (mm_done),
        .busy        (busy),
        .tile_done   (tile_done),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int first_cyc = 0;
    int start_cyc = 0;
    int fp8_bad = 0;
    logic exp_fmt = 1'b0;
    logic prev_start = 1'b0;
    logic [41:0] a_log[$];
    logic [41:0] b_log[$];

    logic [7:0] ta [16] = '{8'd8, 8'd4, 8'd6, 8'd8, 8'd3, 8'd3, 8'd3, 8'd7,
                            8'd5, 8'd2, 8'd1, 8'd6, 8'd9, 8'd1, 8'd0, 8'd5};
    logic [7:0] tb [16] = '{8'd1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd1, 8'd4, 8'd3,
                            8'd3, 8'd5, 8'd3, 8'd1, 8'd9, 8'd6, 8'd3, 8'd2};
    logic [31:0] exp_a [4] = '{32'h09050308, 32'h01020304, 32'h00010306, 32'h05060708};
    logic [31:0] exp_b [4] = '{32'h00030101, 32'h03040100, 32'h01030503, 32'h02030609};
    // Swapped tile (A' = B matrix, B' = A matrix) used for the restart case.
    logic [31:0] exp_a2 [4] = '{32'h09030001, 32'h06050101, 32'h03030403, 32'h02010300};
    logic [31:0] exp_b2 [4] = '{32'h08060408, 32'h07030303, 32'h06010205, 32'h05000109};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_we) a_log.push_back({a_addr, a_wdata});
        if (b_we) b_log.push_back({b_addr, b_wdata});
        if (proto_err) err_cnt++;
        if (tile_done) done_cnt++;
        if (in_valid && in_ready && in_first) first_cyc = cyc;
        if (mm_start && !prev_start) start_cyc = cyc;
        if (mm_start && (mm_is_fp8 !== exp_fmt)) fp8_bad++;
        prev_start = mm_start;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic f, input int gap);
        int  n;
        logic acc;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_byte: in_ready stayed %b for 100 cycles, need 1", acc);
        end
    endtask

    task automatic send_tile(input logic [7:0] a [16], input logic [7:0] b [16],
                             input int nbytes, input int maxgap);
        for (int i = 0; i < nbytes; i++) begin
            send_byte((i < 16) ? a[i] : b[i-16], (i == 0),
                      (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic run_matmul(input int hold);
        int n;
        int restarts;
        n = 0;
        while (mm_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        total++;
        if (mm_start !== 1'b1) begin
            bad++;
            $display("FAIL mm_start_rise: mm_start=%b after %0d cycles, need 1", mm_start, n);
        end
        repeat (50) step();
        mm_done = 1'b1;
        step();
        total++;
        if (mm_start !== 1'b0 || tile_done !== 1'b1) begin
            bad++;
            $display("FAIL done_response: mm_start=%b tile_done=%b, need 0/1", mm_start, tile_done);
        end
        restarts = 0;
        repeat (hold) begin
            step();
            if (mm_start !== 1'b0 || busy !== 1'b1) restarts++;
        end
        total++;
        if (restarts != 0) begin
            bad++;
            $display("FAIL stale_done_hold: %0d bad cycles, need 0", restarts);
        end
        mm_done = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL return_idle: busy=%b, need 0", busy);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready, a_we, b_we, mm_start, busy, tile_done, proto_err, mm_is_fp8} !== 8'h00 ||
            a_addr !== 10'h0 || b_addr !== 10'h0 || a_wdata !== 32'h0 || b_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: ctl=%b a_addr=%h b_addr=%h, need all 0",
                     {in_ready, a_we, b_we, mm_start, busy, tile_done, proto_err, mm_is_fp8},
                     a_addr, b_addr);
        end
    endtask

    task automatic test_basic();
        a_log.delete();
        b_log.delete();
        exp_fmt = 1'b0;
        cfg_is_fp8 = 1'b0;
        base_addr_a = 10'h000;
        base_addr_b = 10'h000;
        send_tile(ta, tb, 32, 0);
        run_matmul(10);
        total++;
        if (start_cyc - first_cyc != 37) begin
            bad++;
            $display("FAIL start_latency: got %0d cycles, need 37", start_cyc - first_cyc);
        end
        total++;
        if (a_log.size() != 4 || b_log.size() != 4) begin
            bad++;
            $display("FAIL basic_wr_count: a=%0d b=%0d, need 4/4", a_log.size(), b_log.size());
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_log[k] !== {10'(k), exp_a[k]}) begin
                bad++;
                $display("FAIL basic_a%0d: got %h, need %h", k, a_log[k], {10'(k), exp_a[k]});
            end
            total++;
            if (b_log[k] !== {10'(k), exp_b[k]}) begin
                bad++;
                $display("FAIL basic_b%0d: got %h, need %h", k, b_log[k], {10'(k), exp_b[k]});
            end
        end
        total++;
        if (fp8_bad != 0) begin
            bad++;
            $display("FAIL basic_fmt: %0d RUN cycles with wrong mm_is_fp8, need 0", fp8_bad);
        end
    endtask

    task automatic test_gaps_fp8();
        a_log.delete();
        b_log.delete();
        exp_fmt = 1'b1;
        fp8_bad = 0;
        cfg_is_fp8 = 1'b1;
        base_addr_a = 10'h020;
        base_addr_b = 10'h140;
        send_tile(ta, tb, 32, 3);
        cfg_is_fp8 = 1'b0;
        run_matmul(0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_log[k] !== {10'h020 + 10'(k), exp_a[k]}) begin
                bad++;
                $display("FAIL gaps_a%0d: got %h, need %h", k, a_log[k], {10'h020 + 10'(k), exp_a[k]});
            end
            total++;
            if (b_log[k] !== {10'h140 + 10'(k), exp_b[k]}) begin
                bad++;
                $display("FAIL gaps_b%0d: got %h, need %h", k, b_log[k], {10'h140 + 10'(k), exp_b[k]});
            end
        end
        total++;
        if (fp8_bad != 0 || mm_is_fp8 !== 1'b1) begin
            bad++;
            $display("FAIL gaps_fmt: bad_cycles=%0d mm_is_fp8=%b, need 0/1", fp8_bad, mm_is_fp8);
        end
    endtask

    task automatic test_no_first();
        int e0;
        a_log.delete();
        b_log.delete();
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0, 0);
        step();
        total++;
        if (err_cnt - e0 != 5 || a_log.size() != 0 || b_log.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL no_first: errs=%0d writes=%0d/%0d busy=%b, need 5 0/0 0",
                     err_cnt - e0, a_log.size(), b_log.size(), busy);
        end
    endtask

    task automatic test_restart();
        int e0;
        a_log.delete();
        b_log.delete();
        exp_fmt = 1'b0;
        fp8_bad = 0;
        base_addr_a = 10'h000;
        base_addr_b = 10'h000;
        e0 = err_cnt;
        send_tile(ta, tb, 22, 0);
        send_tile(tb, ta, 32, 0);
        run_matmul(0);
        total++;
        if (err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL restart_err: got %0d pulses, need 1", err_cnt - e0);
        end
        total++;
        if (a_log.size() != 8 || b_log.size() != 5) begin
            bad++;
            $display("FAIL restart_wr_count: a=%0d b=%0d, need 8/5", a_log.size(), b_log.size());
        end
        total++;
        if (b_log[0] !== {10'h000, exp_b[0]}) begin
            bad++;
            $display("FAIL restart_old_b0: got %h, need %h", b_log[0], {10'h000, exp_b[0]});
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_log[k+4] !== {10'(k), exp_a2[k]}) begin
                bad++;
                $display("FAIL restart_a%0d: got %h, need %h", k, a_log[k+4], {10'(k), exp_a2[k]});
            end
            total++;
            if (b_log[k+1] !== {10'(k), exp_b2[k]}) begin
                bad++;
                $display("FAIL restart_b%0d: got %h, need %h", k, b_log[k+1], {10'(k), exp_b2[k]});
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_aa [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [9:0] exp_ba [4] = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
        a_log.delete();
        b_log.delete();
        base_addr_a = 10'h3FE;
        base_addr_b = 10'h3FD;
        send_tile(ta, tb, 32, 0);
        run_matmul(0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_log[k] !== {exp_aa[k], exp_a[k]} || b_log[k] !== {exp_ba[k], exp_b[k]}) begin
                bad++;
                $display("FAIL wrap_%0d: a=%h b=%h, need %h %h", k, a_log[k], b_log[k],
                         {exp_aa[k], exp_a[k]}, {exp_ba[k], exp_b[k]});
            end
        end
    endtask

    task automatic test_async_reset();
        int d0;
        a_log.delete();
        b_log.delete();
        base_addr_a = 10'h000;
        base_addr_b = 10'h000;
        cfg_is_fp8 = 1'b1;
        exp_fmt = 1'b1;
        d0 = done_cnt;
        send_tile(ta, tb, 22, 0);
        #3;
        resetn = 1'b0;
        #1;
        total++;
        if ({in_ready, a_we, b_we, mm_start, busy, tile_done, proto_err, mm_is_fp8} !== 8'h00 ||
            b_addr !== 10'h0 || b_wdata !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: ctl=%b b_addr=%h b_wdata=%h, need all 0",
                     {in_ready, a_we, b_we, mm_start, busy, tile_done, proto_err, mm_is_fp8},
                     b_addr, b_wdata);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d tile_done pulses, need 0", done_cnt - d0);
        end
        a_log.delete();
        b_log.delete();
        fp8_bad = 0;
        send_tile(ta, tb, 32, 0);
        cfg_is_fp8 = 1'b0;
        run_matmul(0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_log[k] !== {10'(k), exp_a[k]} || b_log[k] !== {10'(k), exp_b[k]}) begin
                bad++;
                $display("FAIL post_reset_%0d: a=%h b=%h, need %h %h", k, a_log[k], b_log[k],
                         {10'(k), exp_a[k]}, {10'(k), exp_b[k]});
            end
        end
        total++;
        if (done_cnt - d0 != 1 || fp8_bad != 0) begin
            bad++;
            $display("FAIL post_reset_done: pulses=%0d fmt_bad=%0d, need 1/0", done_cnt - d0, fp8_bad);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        step();
        test_basic();
        test_gaps_fp8();
        test_no_first();
        test_restart();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
